// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready/data stream bundle for pipe_stage_reg
// Purpose: one direction of a valid/ready handshake carrying a DATA_WIDTH payload.
// Signals:
//   valid  producer has data this cycle
//   ready  consumer accepts data this cycle
//   data   payload
// Modports: master drives valid/data and samples ready; slave is the mirror.
interface pipe_stage_reg_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic two-entry pipeline register with flush, freeze and stall counter
// Purpose: carries a DATA_WIDTH payload between pipeline stages under valid/ready with a
//          registered upstream ready (skid buffer), plus a saturating stall counter.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush_i      discard both entries at the next edge (wins over freeze and accept)
//   freeze_i     hold contents, block both handshakes
//   clr_stats_i  clear stall counter (wins over increment)
//   in_if        upstream stream (slave): valid/data in, ready out
//   out_if       downstream stream (master): valid/data out, ready in
//   occupancy_o  entries held: 0, 1 or 2
//   stall_cnt_o  saturating count of cycles with data held but not taken
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 freeze_i,
  input  logic                 clr_stats_i,
  pipe_stage_reg_if.slave      in_if,
  pipe_stage_reg_if.master     out_if,
  output logic [1:0]           occupancy_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  // Encoding equals the entry count so occupancy is a direct flop output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;

  logic m_v, s_v, accept, fire;

  assign m_v = (state_q != EMPTY);
  assign s_v = (state_q == FULL);

  // Upstream ready depends only on flops and freeze, never on downstream ready.
  assign in_if.ready  = !s_v && !freeze_i;
  assign out_if.valid = m_v && !freeze_i;
  assign out_if.data  = main_q;

  assign accept = in_if.valid && in_if.ready;
  assign fire   = out_if.valid && out_if.ready;

  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_if.data;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_d = in_if.data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_if.data;
          end else if (fire) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain can happen.
          if (fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Freeze cycles with data held count as stalls since nothing leaves.
  always_comb begin
    stall_d = stall_q;
    if (clr_stats_i) begin
      stall_d = '0;
    end else if (m_v && !fire && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        freeze;
  logic        clr;
  logic [1:0]  occ;
  logic [15:0] stall;

  logic        clr4;
  logic [1:0]  occ4;
  logic [3:0]  stall4;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] sb[$];
  logic [63:0] exp_d;

  pipe_stage_reg_if #(.DATA_WIDTH(64)) up_if();
  pipe_stage_reg_if #(.DATA_WIDTH(64)) dn_if();
  pipe_stage_reg_if #(.DATA_WIDTH(64)) up4_if();
  pipe_stage_reg_if #(.DATA_WIDTH(64)) dn4_if();

  pipe_stage_reg #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .freeze_i    (freeze),
    .clr_stats_i (clr),
    .in_if       (up_if),
    .out_if      (dn_if),
    .occupancy_o (occ),
    .stall_cnt_o (stall)
  );

  pipe_stage_reg #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (1'b0),
    .freeze_i    (1'b0),
    .clr_stats_i (clr4),
    .in_if       (up4_if),
    .out_if      (dn4_if),
    .occupancy_o (occ4),
    .stall_cnt_o (stall4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [63:0] d, input logic r);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = r;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on every downstream handshake, push on every upstream handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (dn_if.valid && dn_if.ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_extra: got %0h expected no output", dn_if.data);
        end else begin
          exp_d = sb.pop_front();
          chk("sb_data", dn_if.data, exp_d);
        end
      end
      if (flush) sb.delete();
      else if (up_if.valid && up_if.ready) sb.push_back(up_if.data);
    end
  end

  initial begin
    clk = 0; rst = 0; flush = 0; freeze = 0; clr = 0; clr4 = 0;
    up_if.valid = 0; up_if.data = '0; dn_if.ready = 0;
    up4_if.valid = 0; up4_if.data = '0; dn4_if.ready = 0;
    #1 rst = 1;
    #1;
    chk("rst_out_valid", {63'd0, dn_if.valid}, 64'd0);
    chk("rst_out_data", dn_if.data, 64'd0);
    chk("rst_occ", {62'd0, occ}, 64'd0);
    chk("rst_stall", {48'd0, stall}, 64'd0);
    chk("rst_in_ready", {63'd0, up_if.ready}, 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 64'(i), 1'b1);
      chk("stream_occ", {62'd0, occ}, 64'd1);
      chk("stream_out_data", dn_if.data, 64'(i));
    end
    cyc(1'b0, 64'd0, 1'b1);
    chk("stream_occ_end", {62'd0, occ}, 64'd0);
    chk("stream_stall", {48'd0, stall}, 64'd0);

    // Back-pressure: out_ready low for three cycles
    cyc(1'b1, 64'h11, 1'b1);
    cyc(1'b1, 64'h12, 1'b0);
    chk("bp_occ_full", {62'd0, occ}, 64'd2);
    chk("bp_in_ready_low", {63'd0, up_if.ready}, 64'd0);
    cyc(1'b1, 64'h13, 1'b0);
    cyc(1'b1, 64'h13, 1'b0);
    cyc(1'b1, 64'h13, 1'b1);
    chk("bp_occ_drain", {62'd0, occ}, 64'd1);
    chk("bp_in_ready_back", {63'd0, up_if.ready}, 64'd1);
    cyc(1'b1, 64'h13, 1'b1);
    cyc(1'b1, 64'h14, 1'b1);
    cyc(1'b1, 64'h15, 1'b1);
    cyc(1'b1, 64'h16, 1'b1);
    cyc(1'b0, 64'd0, 1'b1);
    chk("bp_stall", {48'd0, stall}, 64'd3);
    chk("bp_occ_end", {62'd0, occ}, 64'd0);

    // Flush while FULL with C offered
    cyc(1'b1, 64'hA1, 1'b0);
    cyc(1'b1, 64'hB2, 1'b0);
    chk("fl_occ_full", {62'd0, occ}, 64'd2);
    flush = 1;
    cyc(1'b1, 64'hC3, 1'b0);
    flush = 0;
    chk("fl_occ", {62'd0, occ}, 64'd0);
    chk("fl_out_valid", {63'd0, dn_if.valid}, 64'd0);
    chk("fl_out_data", dn_if.data, 64'd0);
    cyc(1'b1, 64'hD4, 1'b1);
    chk("fl_first_after", dn_if.data, 64'hD4);
    cyc(1'b0, 64'd0, 1'b1);
    chk("fl_stall", {48'd0, stall}, 64'd5);

    // Freeze for four cycles holding 0x55, then freeze+flush
    cyc(1'b1, 64'h55, 1'b0);
    freeze = 1;
    up_if.valid = 1; up_if.data = 64'h66; dn_if.ready = 1;
    #1;
    chk("fz_in_ready", {63'd0, up_if.ready}, 64'd0);
    chk("fz_out_valid", {63'd0, dn_if.valid}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 64'h66, 1'b1);
      chk("fz_hold_data", dn_if.data, 64'h55);
      chk("fz_hold_occ", {62'd0, occ}, 64'd1);
    end
    chk("fz_stall", {48'd0, stall}, 64'd9);
    flush = 1;
    cyc(1'b1, 64'h66, 1'b1);
    flush = 0; freeze = 0; up_if.valid = 0;
    chk("fzfl_occ", {62'd0, occ}, 64'd0);
    chk("fzfl_out_data", dn_if.data, 64'd0);
    chk("fzfl_stall", {48'd0, stall}, 64'd10);

    // Asynchronous reset mid-cycle while FULL
    cyc(1'b1, 64'h71, 1'b0);
    cyc(1'b1, 64'h72, 1'b0);
    chk("ar_occ_full", {62'd0, occ}, 64'd2);
    chk("ar_stall_pre", {48'd0, stall}, 64'd11);
    up_if.valid = 0;
    #2 rst = 1;
    #1;
    chk("ar_occ", {62'd0, occ}, 64'd0);
    chk("ar_out_valid", {63'd0, dn_if.valid}, 64'd0);
    chk("ar_out_data", dn_if.data, 64'd0);
    chk("ar_stall", {48'd0, stall}, 64'd0);
    chk("ar_in_ready", {63'd0, up_if.ready}, 64'd1);
    @(posedge clk); #1;
    rst = 0;
    cyc(1'b1, 64'h81, 1'b1);
    chk("ar_first_valid", {63'd0, dn_if.valid}, 64'd1);
    chk("ar_first_data", dn_if.data, 64'h81);
    cyc(1'b0, 64'd0, 1'b1);
    chk("ar_occ_end", {62'd0, occ}, 64'd0);

    // Saturation on the 4-bit counter instance
    up4_if.valid = 1; up4_if.data = 64'h9; dn4_if.ready = 0;
    @(posedge clk); #1;
    up4_if.valid = 0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("sat_stall", {60'd0, stall4}, 64'd15);
    chk("sat_data", dn4_if.data, 64'h9);
    chk("sat_occ", {62'd0, occ4}, 64'd1);
    clr4 = 1;
    @(posedge clk); #1;
    clr4 = 0;
    chk("sat_clr", {60'd0, stall4}, 64'd0);
    dn4_if.ready = 1;
    @(posedge clk); #1;
    chk("sat_drain_occ", {62'd0, occ4}, 64'd0);
    chk("sat_drain_stall", {60'd0, stall4}, 64'd0);

    @(posedge clk); #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
